// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with a single outstanding memory request
// Holds one output slot for the F/D register; redirects cancel in-flight responses via KILL.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        iaddr_ok,
  input  logic        idata_ok,
  input  logic [31:0] irdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        misaligned;

  assign misaligned = (pc[1:0] != 2'b00);
  assign ireq       = (state == S_REQ) && !misaligned;
  assign iaddr      = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_instr <= 32'h0;
      out_adel  <= 1'b0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      out_valid <= 1'b0;
      // An accepted-but-unreturned request must be drained before issuing a new one
      case (state)
        S_REQ:   state <= ireq && iaddr_ok ? S_KILL : S_REQ;
        S_WAIT:  state <= idata_ok ? S_REQ : S_KILL;
        S_KILL:  state <= idata_ok ? S_REQ : S_KILL;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            out_valid <= 1'b1;
            out_adel  <= 1'b1;
            out_pc    <= pc;
            out_instr <= 32'h0;
            state     <= S_HOLD;
          end else if (iaddr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (idata_ok) begin
            out_valid <= 1'b1;
            out_adel  <= 1'b0;
            out_pc    <= pc;
            out_instr <= irdata;
            pc        <= pc + 32'd4;
            state     <= S_HOLD;
          end
        end
        S_KILL: begin
          if (idata_ok) state <= S_REQ;
        end
        default: begin
          if (!stall) begin
            out_valid <= 1'b0;
            state     <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
// Stimulus pushes expected slots; the monitor compares each newly presented slot.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, iaddr_ok, idata_ok;
  logic [31:0] redirect_pc, irdata;
  logic        ireq, out_valid, out_adel;
  logic [31:0] iaddr, out_pc, out_instr;

  int errors = 0;
  int checks = 0;
  logic [64:0] exp_q[$];
  logic        prev_valid = 1'b0;
  logic        done = 1'b0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq(ireq), .iaddr(iaddr), .iaddr_ok(iaddr_ok),
    .idata_ok(idata_ok), .irdata(irdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising out_valid must match the oldest expected slot
  always @(negedge clk) begin
    if (!done && reset === 1'b0) begin
      if (out_valid === 1'b1 && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_slot: got pc=%h instr=%h expected none", out_pc, out_instr);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("slot_pc", out_pc, e[64:33]);
          chk("slot_instr", out_instr, e[32:1]);
          chk("slot_adel", {31'h0, out_adel}, {31'h0, e[0]});
        end
      end
      prev_valid <= (out_valid === 1'b1);
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    iaddr_ok = 1'b0; idata_ok = 1'b0; irdata = 32'h0;
    cyc();
    reset = 1'b0;
    chk("rst_ireq", {31'h0, ireq}, 32'h1);
    chk("rst_iaddr", iaddr, 32'hbfc0_0000);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_adel", {31'h0, out_adel}, 32'h0);

    // Basic fetch, then 5 stalled cycles
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    chk("wait_ireq", {31'h0, ireq}, 32'h0);
    cyc();
    idata_ok = 1'b1; irdata = 32'h2408_0001; stall = 1'b1;
    exp_q.push_back({32'hbfc0_0000, 32'h2408_0001, 1'b0});
    cyc(); idata_ok = 1'b0; irdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ireq", {31'h0, ireq}, 32'h0);
      chk("stall_valid", {31'h0, out_valid}, 32'h1);
      chk("stall_pc", out_pc, 32'hbfc0_0000);
      chk("stall_instr", out_instr, 32'h2408_0001);
      if (i < 4) cyc();
    end
    stall = 1'b0; cyc();
    chk("resume_ireq", {31'h0, ireq}, 32'h1);
    chk("next_iaddr", iaddr, 32'hbfc0_0004);
    chk("resume_valid", {31'h0, out_valid}, 32'h0);

    // Redirect while waiting: returned data must be dropped
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; cyc(); redirect_valid = 1'b0;
    chk("kill_ireq", {31'h0, ireq}, 32'h0);
    idata_ok = 1'b1; irdata = 32'hdead_beef; cyc(); idata_ok = 1'b0;
    chk("redir_ireq", {31'h0, ireq}, 32'h1);
    chk("redir_iaddr", iaddr, 32'h8000_0100);

    // Redirect coincident with iaddr_ok
    iaddr_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200; cyc();
    iaddr_ok = 1'b0; redirect_valid = 1'b0;
    chk("kill2_ireq", {31'h0, ireq}, 32'h0);
    chk("kill2_iaddr", iaddr, 32'h8000_0200);
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    chk("kill2_ignore_aok", {31'h0, ireq}, 32'h0);
    idata_ok = 1'b1; irdata = 32'h1111_1111; cyc(); idata_ok = 1'b0;
    chk("kill2_exit_ireq", {31'h0, ireq}, 32'h1);
    chk("kill2_exit_iaddr", iaddr, 32'h8000_0200);

    // Normal fetch at the redirect target
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    idata_ok = 1'b1; irdata = 32'h2222_2222;
    exp_q.push_back({32'h8000_0200, 32'h2222_2222, 1'b0});
    cyc(); idata_ok = 1'b0;
    cyc();
    chk("after2_iaddr", iaddr, 32'h8000_0204);

    // Redirect together with idata_ok in WAIT: data dropped, straight to REQ
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    idata_ok = 1'b1; irdata = 32'h3333_3333; redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    cyc(); idata_ok = 1'b0; redirect_valid = 1'b0;
    chk("wdrop_ireq", {31'h0, ireq}, 32'h1);
    chk("wdrop_iaddr", iaddr, 32'hffff_fffc);

    // PC wraps past 2^32
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    idata_ok = 1'b1; irdata = 32'h4444_4444;
    exp_q.push_back({32'hffff_fffc, 32'h4444_4444, 1'b0});
    cyc(); idata_ok = 1'b0;
    cyc();
    chk("wrap_iaddr", iaddr, 32'h0000_0000);

    // Redirect to misaligned target while HOLD is stalled
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    idata_ok = 1'b1; irdata = 32'h5555_5555; stall = 1'b1;
    exp_q.push_back({32'h0000_0000, 32'h5555_5555, 1'b0});
    cyc(); idata_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; cyc(); redirect_valid = 1'b0;
    chk("hold_redir_valid", {31'h0, out_valid}, 32'h0);
    chk("adel_no_ireq", {31'h0, ireq}, 32'h0);
    chk("adel_iaddr", iaddr, 32'h8000_0102);
    exp_q.push_back({32'h8000_0102, 32'h0, 1'b1});
    cyc();
    chk("adel_valid", {31'h0, out_valid}, 32'h1);
    chk("adel_flag", {31'h0, out_adel}, 32'h1);
    chk("adel_hold_ireq", {31'h0, ireq}, 32'h0);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; cyc(); redirect_valid = 1'b0;
    chk("recover_ireq", {31'h0, ireq}, 32'h1);
    chk("recover_iaddr", iaddr, 32'h8000_0300);

    // idata_ok ignored in REQ; reset beats a pending redirect
    idata_ok = 1'b1; irdata = 32'h6666_6666; cyc(); idata_ok = 1'b0;
    chk("req_ignore_dok", {31'h0, ireq}, 32'h1);
    iaddr_ok = 1'b1; cyc(); iaddr_ok = 1'b0;
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1234_5678; cyc();
    reset = 1'b0; redirect_valid = 1'b0;
    chk("rst2_iaddr", iaddr, 32'hbfc0_0000);
    chk("rst2_ireq", {31'h0, ireq}, 32'h1);
    chk("rst2_valid", {31'h0, out_valid}, 32'h0);

    cyc(); cyc();
    done = 1'b1;
    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
